plab4_net_router_input_queue_sep: RTL and testbench
===================================================

# plab4_net_router_input_queue_sep

- Domain-separated input buffering stage for one router input port; sits directly upstream of the per-port input control/round-robin arbitration stage.
- Accepts messages from a single inbound channel that carries a domain tag, and steers each into one of two private FIFOs (domain 1 / domain 2).
- Presents each FIFO's head message, valid and extracted destination field to the downstream control stage.
- No storage, occupancy or handshake state is shared between domains.

## Interface
- p_num_routers, 8, number of routers; c_dest_nbits = $clog2(p_num_routers)
- p_opaque_nbits, 8, opaque field width
- p_payload_nbits, 32, payload field width
- p_num_entries, 2, FIFO depth per domain (power of two, >= 2); c_ptr_nbits = $clog2(p_num_entries), c_cnt_nbits = c_ptr_nbits+1
- c_msg_nbits, derived = 2*c_dest_nbits + p_opaque_nbits + p_payload_nbits; message format {dest, src, opaque, payload}, dest in MSBs
- clk  in  1  clock; one clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- in_domain  in  1  domain tag of inbound message: 0 = domain 1, 1 = domain 2
- in_msg  in  c_msg_nbits  inbound message
- in_val  in  1  inbound valid
- in_rdy  out  1  inbound ready (only for the queue selected by in_domain)
- out_msg_d1 / out_msg_d2  out  c_msg_nbits  head entry of each queue
- out_val_d1 / out_val_d2  out  1  queue non-empty
- out_rdy_d1 / out_rdy_d2  in  1  downstream dequeue ready (driven by input ctrl in_rdy_d1/d2)
- dest_d1 / dest_d2  out  c_dest_nbits  out_msg_dX[c_msg_nbits-1 -: c_dest_nbits]
- num_free_d1 / num_free_d2  out  c_cnt_nbits  free entries per queue (for upstream credit tracking)

## Operation
- Per-domain state: storage array [p_num_entries], enq_ptr, deq_ptr (c_ptr_nbits, wrap modulo p_num_entries), count (c_cnt_nbits, 0..p_num_entries).
- Steering: enq_d1 = in_val & in_rdy & ~in_domain; enq_d2 = in_val & in_rdy & in_domain.
- in_rdy = in_domain ? (count_d2 != p_num_entries) : (count_d1 != p_num_entries); combinational from in_domain and the selected queue's registered count only; never depends on the other queue.
- Dequeue: deq_dX = out_val_dX & out_rdy_dX; out_val_dX = (count_dX != 0).
- Full queue: in_rdy low even if a dequeue occurs that cycle (no full-bypass); in_rdy must not depend on out_rdy.
- Empty queue: no enqueue-to-output bypass; out_val low even if an enqueue occurs that cycle.
- Simultaneous enq and deq on the same non-full, non-empty queue: both pointers advance, count unchanged.
- Pointers wrap from p_num_entries-1 to 0.
- num_free_dX = p_num_entries - count_dX.
- out_msg_dX/dest_dX when out_val_dX=0: don't-care; a bench must not check them.
- Domain 1 data/control depends only on domain-1 inputs and in_domain; likewise domain 2. in_domain is public (low) control.

## Timing
- Reset (sync, sampled at posedge): all pointers and counts 0 → out_val_d1 = out_val_d2 = 0, num_free_dX = p_num_entries, in_rdy = 1 for either in_domain value. Reset overrides any enq/deq in the same cycle; in-flight entries are discarded.
- Latency: message enqueued at edge N is visible on out_msg_dX/out_val_dX after edge N (one cycle), provided it is at the head.
- Throughput: one enqueue (to one domain) plus up to one dequeue per domain per cycle; with p_num_entries >= 2, full rate is sustained per domain.
- No combinational path from in_* to out_*, or from out_rdy_* to in_rdy.
- Ordering: FIFO within a domain; no ordering relation between domains.

## Test plan
- Reset then idle: out_val_d1 = out_val_d2 = 0, num_free_d1 = num_free_d2 = 2, in_rdy = 1 for in_domain 0 and 1.
- Single enqueue, in_domain=0, in_msg dest=5, payload 0xCAFE0001:
  - next cycle out_val_d1=1, dest_d1=5, out_msg_d1 matches, out_val_d2=0;
  - dequeue with out_rdy_d1=1 → out_val_d1=0 the following cycle.
- Fill domain 2 with 2 messages, out_rdy_d2=0:
  - in_rdy=0 for in_domain=1 and 1 for in_domain=0;
  - a domain-1 message is still accepted;
  - num_free_d2=0.
- Full domain 2, then out_rdy_d2=1 and in_val=1 with in_domain=1 in the same cycle: the dequeue happens, the enqueue is refused (in_rdy=0); in_rdy=1 next cycle.
- Streaming 8 messages into domain 1 (payload 0..7) with out_rdy_d1 held 1: one output per cycle, in order 0..7 across pointer wrap; count never exceeds 2.
- Reset asserted with both queues holding 1 entry: next cycle both out_val low, num_free=2; subsequent traffic behaves as after power-on reset.

Source files
------------

// File: rtl/plab4_net_router_input_queue_sep_if.sv
// Inbound channel and per-domain outbound heads of the domain-separated
// router input queue; the queue block is the slave side.
interface plab4_net_router_input_queue_sep_if #(
   parameter int p_num_routers   = 8,
   parameter int p_opaque_nbits  = 8,
   parameter int p_payload_nbits = 32,
   parameter int p_num_entries   = 2
);
   localparam int c_dest_nbits = $clog2(p_num_routers);
   localparam int c_ptr_nbits  = $clog2(p_num_entries);
   localparam int c_cnt_nbits  = c_ptr_nbits + 1;
   localparam int c_msg_nbits  = 2*c_dest_nbits + p_opaque_nbits + p_payload_nbits;

   logic                    in_domain;
   logic [c_msg_nbits-1:0]  in_msg;
   logic                    in_val;
   logic                    in_rdy;

   logic [c_msg_nbits-1:0]  out_msg_d1;
   logic                    out_val_d1;
   logic                    out_rdy_d1;
   logic [c_dest_nbits-1:0] dest_d1;
   logic [c_cnt_nbits-1:0]  num_free_d1;

   logic [c_msg_nbits-1:0]  out_msg_d2;
   logic                    out_val_d2;
   logic                    out_rdy_d2;
   logic [c_dest_nbits-1:0] dest_d2;
   logic [c_cnt_nbits-1:0]  num_free_d2;

   modport master (
      output in_domain, in_msg, in_val, out_rdy_d1, out_rdy_d2,
      input  in_rdy, out_msg_d1, out_val_d1, dest_d1, num_free_d1,
             out_msg_d2, out_val_d2, dest_d2, num_free_d2
   );

   modport slave (
      input  in_domain, in_msg, in_val, out_rdy_d1, out_rdy_d2,
      output in_rdy, out_msg_d1, out_val_d1, dest_d1, num_free_d1,
             out_msg_d2, out_val_d2, dest_d2, num_free_d2
   );
endinterface

// File: rtl/plab4_net_router_input_queue_sep.sv
// Router input-port buffer that steers inbound messages by domain tag into
// two fully private FIFOs and exposes each FIFO head to the input control.

module plab4_net_router_input_queue_sep_fifo #(
   parameter  int p_num_entries = 2,
   parameter  int p_msg_nbits   = 46,
   localparam int c_ptr_nbits   = $clog2(p_num_entries),
   localparam int c_cnt_nbits   = c_ptr_nbits + 1
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_val,
   input  logic [p_msg_nbits-1:0] enq_msg,
   output logic                   full,
   input  logic                   deq_rdy,
   output logic                   deq_val,
   output logic [p_msg_nbits-1:0] deq_msg,
   output logic [c_cnt_nbits-1:0] num_free
);
   localparam logic [c_cnt_nbits-1:0] c_full_cnt = c_cnt_nbits'(p_num_entries);
   localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
   localparam logic [c_cnt_nbits-1:0] c_cnt_zero = c_cnt_nbits'(0);
   localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_num_entries - 1);
   localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);
   localparam logic [c_ptr_nbits-1:0] c_ptr_zero = c_ptr_nbits'(0);

   logic [p_msg_nbits-1:0] mem_r [p_num_entries];
   logic [c_ptr_nbits-1:0] enq_ptr_r;
   logic [c_ptr_nbits-1:0] deq_ptr_r;
   logic [c_cnt_nbits-1:0] count_r;

   logic full_s;
   logic enq_s;
   logic deq_val_s;
   logic deq_s;

   function automatic logic [c_ptr_nbits-1:0] ptr_next(input logic [c_ptr_nbits-1:0] ptr);
      if (ptr == c_last_ptr) begin
         ptr_next = c_ptr_zero;
      end else begin
         ptr_next = ptr + c_ptr_one;
      end
   endfunction

   // Handshake qualification from registered occupancy only (no bypass paths)
   always_comb begin
      full_s    = (count_r == c_full_cnt);
      deq_val_s = (count_r != c_cnt_zero);
      enq_s     = enq_val & ~full_s;
      deq_s     = deq_rdy & deq_val_s;
   end

   // Pointer and occupancy update; reset discards anything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         enq_ptr_r <= c_ptr_zero;
         deq_ptr_r <= c_ptr_zero;
         count_r   <= c_cnt_zero;
      end else begin
         if (enq_s) begin
            enq_ptr_r <= ptr_next(enq_ptr_r);
         end
         if (deq_s) begin
            deq_ptr_r <= ptr_next(deq_ptr_r);
         end
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + c_cnt_one;
            2'b01:   count_r <= count_r - c_cnt_one;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage write port
   always_ff @(posedge clk) begin
      if (!reset && enq_s) begin
         mem_r[enq_ptr_r] <= enq_msg;
      end
   end

   assign full     = full_s;
   assign deq_val  = deq_val_s;
   assign deq_msg  = mem_r[deq_ptr_r];
   assign num_free = c_full_cnt - count_r;
endmodule

module plab4_net_router_input_queue_sep_checker #(
   parameter  int p_num_entries = 2,
   localparam int c_cnt_nbits   = $clog2(p_num_entries) + 1
)(
   input logic                   clk,
   input logic                   reset,
   input logic                   in_domain,
   input logic                   in_rdy,
   input logic                   out_val_d1,
   input logic                   out_rdy_d1,
   input logic [c_cnt_nbits-1:0] num_free_d1,
   input logic                   out_val_d2,
   input logic                   out_rdy_d2,
   input logic [c_cnt_nbits-1:0] num_free_d2
);
   localparam logic [c_cnt_nbits-1:0] c_full_cnt = c_cnt_nbits'(p_num_entries);
   localparam logic [c_cnt_nbits-1:0] c_cnt_zero = c_cnt_nbits'(0);

   a_free_bound_d1: assert property (@(posedge clk) disable iff (reset)
      num_free_d1 <= c_full_cnt);
   a_free_bound_d2: assert property (@(posedge clk) disable iff (reset)
      num_free_d2 <= c_full_cnt);
   a_val_free_d1: assert property (@(posedge clk) disable iff (reset)
      out_val_d1 == (num_free_d1 != c_full_cnt));
   a_val_free_d2: assert property (@(posedge clk) disable iff (reset)
      out_val_d2 == (num_free_d2 != c_full_cnt));
   a_rdy_d1: assert property (@(posedge clk) disable iff (reset)
      !in_domain |-> (in_rdy == (num_free_d1 != c_cnt_zero)));
   a_rdy_d2: assert property (@(posedge clk) disable iff (reset)
      in_domain |-> (in_rdy == (num_free_d2 != c_cnt_zero)));
   a_hold_d1: assert property (@(posedge clk) disable iff (reset)
      (out_val_d1 && !out_rdy_d1) |=> out_val_d1);
   a_hold_d2: assert property (@(posedge clk) disable iff (reset)
      (out_val_d2 && !out_rdy_d2) |=> out_val_d2);
endmodule

module plab4_net_router_input_queue_sep #(
   parameter  int p_num_routers   = 8,
   parameter  int p_opaque_nbits  = 8,
   parameter  int p_payload_nbits = 32,
   parameter  int p_num_entries   = 2,
   localparam int c_dest_nbits    = $clog2(p_num_routers),
   localparam int c_msg_nbits     = 2*c_dest_nbits + p_opaque_nbits + p_payload_nbits
)(
   input logic clk,
   input logic reset,
   plab4_net_router_input_queue_sep_if.slave q
);
   logic full_d1_s;
   logic full_d2_s;
   logic enq_val_d1_s;
   logic enq_val_d2_s;
   logic in_rdy_s;

   // Domain steering: only the selected queue's fullness gates the inbound side
   always_comb begin
      enq_val_d1_s = 1'b0;
      enq_val_d2_s = 1'b0;
      in_rdy_s     = 1'b0;
      if (q.in_domain) begin
         enq_val_d2_s = q.in_val;
         in_rdy_s     = ~full_d2_s;
      end else begin
         enq_val_d1_s = q.in_val;
         in_rdy_s     = ~full_d1_s;
      end
   end

   plab4_net_router_input_queue_sep_fifo #(
      .p_num_entries (p_num_entries),
      .p_msg_nbits   (c_msg_nbits)
   ) u_fifo_d1 (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (enq_val_d1_s),
      .enq_msg  (q.in_msg),
      .full     (full_d1_s),
      .deq_rdy  (q.out_rdy_d1),
      .deq_val  (q.out_val_d1),
      .deq_msg  (q.out_msg_d1),
      .num_free (q.num_free_d1)
   );

   plab4_net_router_input_queue_sep_fifo #(
      .p_num_entries (p_num_entries),
      .p_msg_nbits   (c_msg_nbits)
   ) u_fifo_d2 (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (enq_val_d2_s),
      .enq_msg  (q.in_msg),
      .full     (full_d2_s),
      .deq_rdy  (q.out_rdy_d2),
      .deq_val  (q.out_val_d2),
      .deq_msg  (q.out_msg_d2),
      .num_free (q.num_free_d2)
   );

   assign q.in_rdy  = in_rdy_s;
   assign q.dest_d1 = q.out_msg_d1[c_msg_nbits-1 -: c_dest_nbits];
   assign q.dest_d2 = q.out_msg_d2[c_msg_nbits-1 -: c_dest_nbits];

   plab4_net_router_input_queue_sep_checker #(
      .p_num_entries (p_num_entries)
   ) u_checker (
      .clk         (clk),
      .reset       (reset),
      .in_domain   (q.in_domain),
      .in_rdy      (in_rdy_s),
      .out_val_d1  (q.out_val_d1),
      .out_rdy_d1  (q.out_rdy_d1),
      .num_free_d1 (q.num_free_d1),
      .out_val_d2  (q.out_val_d2),
      .out_rdy_d2  (q.out_rdy_d2),
      .num_free_d2 (q.num_free_d2)
   );
endmodule

// File: tb/tb_plab4_net_router_input_queue_sep.sv
// Directed bench for the domain-separated router input queue.
module tb_plab4_net_router_input_queue_sep;
   localparam int NR = 8;
   localparam int NE = 2;
   localparam int MSGW = 2*3 + 8 + 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_checks = 0;
   int n_errors = 0;

   plab4_net_router_input_queue_sep_if #(
      .p_num_routers(NR), .p_opaque_nbits(8), .p_payload_nbits(32), .p_num_entries(NE)
   ) q ();

   plab4_net_router_input_queue_sep #(
      .p_num_routers(NR), .p_opaque_nbits(8), .p_payload_nbits(32), .p_num_entries(NE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .q     (q)
   );

   always #5 clk = ~clk;

   function automatic logic [MSGW-1:0] mk_msg(input logic [2:0] dest, input logic [2:0] src,
                                              input logic [7:0] opq, input logic [31:0] pay);
      mk_msg = {dest, src, opq, pay};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; q.in_val = 1'b0; q.in_domain = 1'b0; q.in_msg = '0;
      q.out_rdy_d1 = 1'b0; q.out_rdy_d2 = 1'b0;
      step; step;
      reset = 1'b0;
      #1;
      n_checks++; if (q.out_val_d1 !== 1'b0) begin n_errors++; $display("FAIL reset_val_d1: got %0h expected 0", q.out_val_d1); end
      n_checks++; if (q.out_val_d2 !== 1'b0) begin n_errors++; $display("FAIL reset_val_d2: got %0h expected 0", q.out_val_d2); end
      n_checks++; if (q.num_free_d1 !== 2'd2) begin n_errors++; $display("FAIL reset_free_d1: got %0d expected 2", q.num_free_d1); end
      n_checks++; if (q.num_free_d2 !== 2'd2) begin n_errors++; $display("FAIL reset_free_d2: got %0d expected 2", q.num_free_d2); end
      n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_rdy_dom0: got %0h expected 1", q.in_rdy); end
      q.in_domain = 1'b1; #1;
      n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_rdy_dom1: got %0h expected 1", q.in_rdy); end
      step;
   endtask

   task automatic test_single_enq;
      logic [MSGW-1:0] m;
      m = mk_msg(3'd5, 3'd1, 8'h11, 32'hCAFE0001);
      q.in_domain = 1'b0; q.in_val = 1'b1; q.in_msg = m;
      #1;
      n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL single_rdy: got %0h expected 1", q.in_rdy); end
      n_checks++; if (q.out_val_d1 !== 1'b0) begin n_errors++; $display("FAIL single_no_bypass: got %0h expected 0", q.out_val_d1); end
      step;
      q.in_val = 1'b0; #1;
      n_checks++; if (q.out_val_d1 !== 1'b1) begin n_errors++; $display("FAIL single_val_d1: got %0h expected 1", q.out_val_d1); end
      n_checks++; if (q.dest_d1 !== 3'd5) begin n_errors++; $display("FAIL single_dest_d1: got %0d expected 5", q.dest_d1); end
      n_checks++; if (q.out_msg_d1 !== m) begin n_errors++; $display("FAIL single_msg_d1: got %h expected %h", q.out_msg_d1, m); end
      n_checks++; if (q.out_val_d2 !== 1'b0) begin n_errors++; $display("FAIL single_val_d2: got %0h expected 0", q.out_val_d2); end
      n_checks++; if (q.num_free_d1 !== 2'd1) begin n_errors++; $display("FAIL single_free_d1: got %0d expected 1", q.num_free_d1); end
      q.out_rdy_d1 = 1'b1;
      step;
      q.out_rdy_d1 = 1'b0; #1;
      n_checks++; if (q.out_val_d1 !== 1'b0) begin n_errors++; $display("FAIL single_deq_val: got %0h expected 0", q.out_val_d1); end
      n_checks++; if (q.num_free_d1 !== 2'd2) begin n_errors++; $display("FAIL single_deq_free: got %0d expected 2", q.num_free_d1); end
   endtask

   task automatic test_fill_d2;
      logic [MSGW-1:0] ma, mb, mc;
      ma = mk_msg(3'd1, 3'd2, 8'hA0, 32'h0000_00A0);
      mb = mk_msg(3'd6, 3'd2, 8'hB0, 32'h0000_00B0);
      mc = mk_msg(3'd3, 3'd4, 8'hC0, 32'h0000_00C0);
      q.out_rdy_d2 = 1'b0; q.in_domain = 1'b1; q.in_val = 1'b1;
      q.in_msg = ma; step;
      q.in_msg = mb; step;
      q.in_val = 1'b0; #1;
      n_checks++; if (q.num_free_d2 !== 2'd0) begin n_errors++; $display("FAIL fill_free_d2: got %0d expected 0", q.num_free_d2); end
      n_checks++; if (q.out_msg_d2 !== ma) begin n_errors++; $display("FAIL fill_head_d2: got %h expected %h", q.out_msg_d2, ma); end
      n_checks++; if (q.dest_d2 !== 3'd1) begin n_errors++; $display("FAIL fill_dest_d2: got %0d expected 1", q.dest_d2); end
      n_checks++; if (q.in_rdy !== 1'b0) begin n_errors++; $display("FAIL fill_rdy_dom1: got %0h expected 0", q.in_rdy); end
      q.in_domain = 1'b0; #1;
      n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL fill_rdy_dom0: got %0h expected 1", q.in_rdy); end
      q.in_val = 1'b1; q.in_msg = mc;
      step;
      q.in_val = 1'b0; #1;
      n_checks++; if (q.out_val_d1 !== 1'b1) begin n_errors++; $display("FAIL fill_d1_val: got %0h expected 1", q.out_val_d1); end
      n_checks++; if (q.out_msg_d1 !== mc) begin n_errors++; $display("FAIL fill_d1_msg: got %h expected %h", q.out_msg_d1, mc); end
      n_checks++; if (q.num_free_d2 !== 2'd0) begin n_errors++; $display("FAIL fill_d2_untouched: got %0d expected 0", q.num_free_d2); end
      q.out_rdy_d1 = 1'b1; step;
      q.out_rdy_d1 = 1'b0; #1;
      n_checks++; if (q.out_val_d1 !== 1'b0) begin n_errors++; $display("FAIL fill_d1_drain: got %0h expected 0", q.out_val_d1); end
   endtask

   task automatic test_full_no_bypass;
      logic [MSGW-1:0] mb, md;
      mb = mk_msg(3'd6, 3'd2, 8'hB0, 32'h0000_00B0);
      md = mk_msg(3'd7, 3'd7, 8'hD0, 32'h0000_00D0);
      q.in_domain = 1'b1; q.in_val = 1'b1; q.in_msg = md; q.out_rdy_d2 = 1'b1;
      #1;
      n_checks++; if (q.in_rdy !== 1'b0) begin n_errors++; $display("FAIL full_rdy_with_deq: got %0h expected 0", q.in_rdy); end
      step;
      q.in_val = 1'b0; q.out_rdy_d2 = 1'b0; #1;
      n_checks++; if (q.num_free_d2 !== 2'd1) begin n_errors++; $display("FAIL full_free_after: got %0d expected 1", q.num_free_d2); end
      n_checks++; if (q.out_msg_d2 !== mb) begin n_errors++; $display("FAIL full_head_after: got %h expected %h", q.out_msg_d2, mb); end
      n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL full_rdy_next: got %0h expected 1", q.in_rdy); end
      q.out_rdy_d2 = 1'b1; step;
      q.out_rdy_d2 = 1'b0; #1;
      n_checks++; if (q.out_val_d2 !== 1'b0) begin n_errors++; $display("FAIL full_refused_gone: got %0h expected 0", q.out_val_d2); end
      n_checks++; if (q.num_free_d2 !== 2'd2) begin n_errors++; $display("FAIL full_drain_free: got %0d expected 2", q.num_free_d2); end
   endtask

   task automatic test_back_to_back;
      logic exp_val;
      q.in_domain = 1'b0; q.out_rdy_d1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         q.in_val = (i < 8);
         q.in_msg = mk_msg(3'd2, 3'd0, 8'h00, 32'(i));
         #1;
         if (i < 8) begin
            n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL stream_rdy[%0d]: got %0h expected 1", i, q.in_rdy); end
         end
         exp_val = (i >= 1) && (i <= 8);
         n_checks++; if (q.out_val_d1 !== exp_val) begin n_errors++; $display("FAIL stream_val[%0d]: got %0h expected %0h", i, q.out_val_d1, exp_val); end
         if (exp_val) begin
            n_checks++; if (q.out_msg_d1[31:0] !== 32'(i-1)) begin n_errors++; $display("FAIL stream_order[%0d]: got %0d expected %0d", i, q.out_msg_d1[31:0], i-1); end
            n_checks++; if (q.num_free_d1 !== 2'd1) begin n_errors++; $display("FAIL stream_free[%0d]: got %0d expected 1", i, q.num_free_d1); end
         end
         step;
      end
      q.in_val = 1'b0; q.out_rdy_d1 = 1'b0; #1;
      n_checks++; if (q.num_free_d1 !== 2'd2) begin n_errors++; $display("FAIL stream_end_free: got %0d expected 2", q.num_free_d1); end
   endtask

   task automatic test_reset_flush;
      logic [MSGW-1:0] mf;
      mf = mk_msg(3'd4, 3'd3, 8'hF0, 32'h0000_F00F);
      q.in_val = 1'b1; q.in_domain = 1'b0; q.in_msg = mk_msg(3'd1, 3'd1, 8'h01, 32'h1); step;
      q.in_domain = 1'b1; q.in_msg = mk_msg(3'd2, 3'd2, 8'h02, 32'h2); step;
      q.in_val = 1'b0; #1;
      n_checks++; if ({q.out_val_d1, q.out_val_d2} !== 2'b11) begin n_errors++; $display("FAIL flush_pre_vals: got %b expected 11", {q.out_val_d1, q.out_val_d2}); end
      reset = 1'b1; q.in_val = 1'b1; q.in_domain = 1'b0; q.in_msg = mf;
      step;
      reset = 1'b0; q.in_val = 1'b0; #1;
      n_checks++; if ({q.out_val_d1, q.out_val_d2} !== 2'b00) begin n_errors++; $display("FAIL flush_vals: got %b expected 00", {q.out_val_d1, q.out_val_d2}); end
      n_checks++; if (q.num_free_d1 !== 2'd2) begin n_errors++; $display("FAIL flush_free_d1: got %0d expected 2", q.num_free_d1); end
      n_checks++; if (q.num_free_d2 !== 2'd2) begin n_errors++; $display("FAIL flush_free_d2: got %0d expected 2", q.num_free_d2); end
      q.in_domain = 1'b1; q.in_val = 1'b1; q.in_msg = mf; #1;
      n_checks++; if (q.in_rdy !== 1'b1) begin n_errors++; $display("FAIL flush_rdy: got %0h expected 1", q.in_rdy); end
      step;
      q.in_val = 1'b0; #1;
      n_checks++; if (q.out_msg_d2 !== mf) begin n_errors++; $display("FAIL flush_post_msg: got %h expected %h", q.out_msg_d2, mf); end
      n_checks++; if (q.num_free_d2 !== 2'd1) begin n_errors++; $display("FAIL flush_post_free: got %0d expected 1", q.num_free_d2); end
      n_checks++; if (q.out_val_d1 !== 1'b0) begin n_errors++; $display("FAIL flush_post_d1: got %0h expected 0", q.out_val_d1); end
   endtask

   initial begin
      test_reset;
      test_single_enq;
      test_fill_d2;
      test_full_no_bypass;
      test_back_to_back;
      test_reset_flush;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
